// File: rtl/sinc_interp_mc.sv
// Time-multiplexed 2x binomial (1+z^-1)^N interpolator: one input per channel
// in, a phase A / phase B output pair out, with per-channel input history.
module sinc_interp_mc #(
   parameter int WIDTH = 16,
   parameter int ORDER = 5,
   parameter int NCH   = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    enable,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic signed [WIDTH-1:0]                 in_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic signed [WIDTH-1:0]                 out_data,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_chan,
   output logic                                    out_phase
);

   localparam int D  = ORDER / 2;
   localparam int HD = (D > 0) ? D : 1;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SW = WIDTH + ORDER;

   typedef enum logic [1:0] {IDLE, OUT_A, OUT_B} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic signed [WIDTH-1:0] out_data_q, out_data_d;
   logic signed [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]           out_chan_q, out_chan_d;
   logic                    out_phase_q, out_phase_d;
   logic signed [WIDTH-1:0] hist_q [NCH][HD];
   logic signed [WIDTH-1:0] hist_d [NCH][HD];

   logic signed [WIDTH-1:0] xs [D+1];
   logic signed [SW-1:0]    sum_a, sum_b, coef, ext, sh_a, sh_b;
   logic signed [WIDTH-1:0] phase_a, phase_b;

   function automatic int binom(input int unsigned n, input int unsigned k);
      int r;
      r = 1;
      for (int unsigned i = 0; i < k; i++)
         r = r * (int'(n) - int'(i)) / (int'(i) + 1);
      return r;
   endfunction

   // xs[k] is x[n-k]: the incoming sample followed by this channel's history.
   always_comb begin
      xs[0] = in_data;
      for (int unsigned k = 1; k <= D; k++)
         xs[k] = hist_q[ch_q][k-1];
      sum_a = '0;
      sum_b = '0;
      coef  = '0;
      ext   = '0;
      for (int unsigned j = 0; j <= ORDER; j++) begin
         coef = SW'(binom(ORDER, j));
         if (j % 2 == 0) begin
            ext   = xs[j/2];
            sum_a = sum_a + coef * ext;
         end else begin
            ext   = xs[(j-1)/2];
            sum_b = sum_b + coef * ext;
         end
      end
      sh_a    = sum_a >>> (ORDER - 1);
      sh_b    = sum_b >>> (ORDER - 1);
      phase_a = sh_a[WIDTH-1:0];
      phase_b = sh_b[WIDTH-1:0];
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      out_data_d  = out_data_q;
      hold_d      = hold_q;
      out_chan_d  = out_chan_q;
      out_phase_d = out_phase_q;
      hist_d      = hist_q;
      if (!enable) begin
         state_d     = IDLE;
         ch_d        = '0;
         out_data_d  = '0;
         out_chan_d  = '0;
         out_phase_d = 1'b0;
         for (int unsigned c = 0; c < NCH; c++)
            for (int unsigned k = 0; k < HD; k++)
               hist_d[c][k] = '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               out_data_d  = phase_a;
               hold_d      = phase_b;
               out_chan_d  = ch_q;
               out_phase_d = 1'b0;
               state_d     = OUT_A;
               if (D > 0) begin
                  for (int unsigned k = HD - 1; k > 0; k--)
                     hist_d[ch_q][k] = hist_q[ch_q][k-1];
                  hist_d[ch_q][0] = in_data;
               end
               ch_d = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
            end
            OUT_A: if (out_ready) begin
               out_data_d  = hold_q;
               out_phase_d = 1'b1;
               state_d     = OUT_B;
            end
            OUT_B: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         out_data_q  <= '0;
         hold_q      <= '0;
         out_chan_q  <= '0;
         out_phase_q <= 1'b0;
         for (int unsigned c = 0; c < NCH; c++)
            for (int unsigned k = 0; k < HD; k++)
               hist_q[c][k] <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         out_data_q  <= out_data_d;
         hold_q      <= hold_d;
         out_chan_q  <= out_chan_d;
         out_phase_q <= out_phase_d;
         hist_q      <= hist_d;
      end
   end

   // rst_n gates in_ready so it stays low for the whole reset pulse.
   assign in_ready  = enable && rst_n && (state_q == IDLE);
   assign out_valid = (state_q == OUT_A) || (state_q == OUT_B);
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_phase = out_phase_q;

endmodule

// File: doc/sinc_interp_mc.md
SINC_INTERP_MC -- requirements
Module: sinc_interp_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed two's-complement sample width, legal 8..32.
REQ-002 SHALL have parameter ORDER, default 5: binomial order N of (1+z^-1)^N, legal 1..7.
REQ-003 SHALL have parameter NCH, default 4: time-multiplexed channel count, legal 1..16.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1: synchronous run enable; low means flush.
REQ-007 SHALL have port in_valid  in  1: in_data is valid.
REQ-008 SHALL have port in_ready  out  1: block can accept a sample.
REQ-009 SHALL have port in_data  in  WIDTH: signed input sample.
REQ-010 SHALL have port out_valid  out  1: out_data is valid.
REQ-011 SHALL have port out_ready  in  1: downstream accepts out_data.
REQ-012 SHALL have port out_data  out  WIDTH: signed interpolated sample.
REQ-013 SHALL have port out_chan  out  max(1,clog2(NCH)): channel of out_data.
REQ-014 SHALL have port out_phase  out  1: 0 = phase A (even), 1 = phase B (odd).

Function
REQ-015 SHALL interpolate by 2 per channel: two outputs per accepted input, phase A then phase B.
REQ-016 SHALL take the input channel from an internal counter: channel 0 first, +1 per accept, wrap NCH-1 -> 0; no channel input port.
REQ-017 SHALL keep per-channel history H[c][1..D], D = floor(ORDER/2), where H[c][k] is that channel's k-th previous input.
REQ-018 SHALL compute phase A = sum over even j of C(N,j)*x[n-j/2].
REQ-019 SHALL compute phase B = sum over odd j of C(N,j)*x[n-(j-1)/2].
REQ-020 SHALL form each output as the sum arithmetic-shifted right by N-1 (unity DC gain), truncating toward minus infinity.
REQ-021 SHALL use internal sums of at least WIDTH+N bits; no saturation is needed because each phase's coefficients sum to 2^(N-1).
REQ-022 For ORDER=1, SHALL produce phase A = phase B = x[n]; D=0 and no history is kept.
REQ-023 SHALL use FSM states IDLE, OUT_A, OUT_B; in_ready = enable AND state==IDLE.
REQ-024 In IDLE, on in_valid&in_ready, SHALL in the same edge:
- register phase A into out_data and phase B into a hold register
- shift that channel's history (newest = in_data)
- set out_chan = current channel and out_phase = 0
- advance the channel counter
- go to OUT_A
REQ-025 SHALL make out_valid = state in {OUT_A, OUT_B}, so first output appears one cycle after accept.
REQ-026 OUT_A, on out_ready, SHALL load the hold value, set out_phase = 1 and go to OUT_B; without out_ready it SHALL hold all outputs stable.
REQ-027 OUT_B, on out_ready, SHALL go to IDLE; without out_ready it SHALL hold all outputs stable.
REQ-028 SHALL sustain a throughput of one input per 3 cycles when out_ready is held high.
REQ-029 SHALL leave other channels' history untouched when a sample is accepted.
REQ-030 When enable is low, SHALL on the next edge zero all history, the channel counter, out_data, out_chan and out_phase, and go to IDLE, discarding any pending output.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force:
- state = IDLE, out_valid = 0
- out_data, out_chan, out_phase, hold register, channel counter and all history = 0
REQ-032 SHALL keep in_ready = 0 while rst_n is low.
REQ-033 SHALL resume normal operation on the first rising clk edge after rst_n deasserts with enable high.
REQ-034 A reset asserted mid-output SHALL abort the output pair with no further output beats.

Verification (WIDTH=16, ORDER=5, NCH=1 unless stated)
REQ-035 Feed 16, 16, 16 with out_ready=1 -> outputs (A,B) = (1,5), (11,15), (16,16).
REQ-036 Feed -16 then 0, 0 -> outputs (-1,-5), (-10,-10), (-5,-1).
REQ-037 NCH=2: feed 16 (ch0), 32 (ch1), 16 (ch0) -> (1,5) chan0; (2,10) chan1; (11,15) chan0.
REQ-038 Hold out_ready=0 for 4 cycles in OUT_A -> out_data=1, out_phase=0, in_ready=0 held stable; release -> B=5 follows.
REQ-039 Drop enable in OUT_B, then feed 16 -> no B beat; next output (1,5) on chan0.
REQ-040 Assert rst_n low mid-stream -> out_valid=0 immediately; after release, feeding 16 gives (1,5).
